controller_num_entry: RTL and testbench
=======================================

// Module: controller_num_entry
// PURPOSE
//  Digit-entry sequencer between the digit-decode logic and the data stack.
//  Collects per-digit strobes into a BCD entry buffer, with backspace and clear.
//  On commit, converts the entry to binary in multiple cycles, then pushes it
//  to the data stack over a valid/ready handshake.
// PARAMETERS
//  DIGITS  8   max digits held in the entry buffer
//  WIDTH   32  binary result width (matches CD_N)
//  CNT_W   4   digit-counter width; must equal ceil(log2(DIGITS+1))
// PORTS
//  Clock      in   1           system clock, rising edge
//  Reset      in   1           asynchronous reset, active-high
//  dg_D       in   4           digit value 0..9 (values >9 are ignored)
//  dg_EN      in   1           digit strobe, one cycle per digit
//  del_EN     in   1           backspace strobe
//  clr_EN     in   1           clear-entry strobe
//  cmt_EN     in   1           commit strobe
//  out_data   out  WIDTH       binary value pushed to the data stack
//  out_valid  out  1           push request
//  out_ready  in   1           data stack accepts when out_valid&out_ready
//  bcd_Q      out  4*DIGITS    entry buffer; least-significant digit in [3:0]
//  cnt_Q      out  CNT_W       number of digits currently entered
//  ovf        out  1           sticky: a digit was dropped because the buffer was full
//  busy       out  1           high in S_CONV and S_PUSH; all strobes ignored
// BEHAVIOUR
//  Reset: state=S_ENTRY; bcd_Q, cnt_Q, out_data, acc and idx=0;
//   out_valid, ovf and busy=0. Reset aborts any conversion or push
//   with no output.
//  States: S_ENTRY -> (cmt_EN) S_CONV -> (idx==0) S_PUSH -> (out_ready) S_ENTRY.
//  S_ENTRY, one action per cycle, priority clr_EN > cmt_EN > del_EN > dg_EN:
//   clr: bcd_Q=0, cnt_Q=0, ovf=0.
//   cmt: acc=0, idx=cnt_Q. If cnt_Q==0, go straight to S_PUSH with out_data=0.
//   del: bcd_Q>>=4, cnt_Q-=1. No-op when cnt_Q==0.
//   dg:  dg_D>9 is ignored. dg_D==0 with cnt_Q==0 is ignored (no leading zeros).
//        cnt_Q==DIGITS: digit dropped, ovf=1.
//        Otherwise: bcd_Q={bcd_Q,dg_D} truncated to 4*DIGITS bits; cnt_Q+=1.
//  S_CONV: one digit per cycle, most-significant digit first:
//   acc = (acc<<3)+(acc<<1)+bcd_Q[4*idx-1 -: 4], modulo 2^WIDTH; idx-=1.
//   When idx reaches 0: out_data=acc, go to S_PUSH.
//   Conversion takes cnt_Q cycles; out_valid rises the cycle after the last digit.
//  S_PUSH: out_valid=1 with out_data held stable until out_ready is high
//   (ready may be asserted before valid). On transfer: out_valid=0, bcd_Q=0,
//   cnt_Q=0, ovf=0, return to S_ENTRY.
//  Strobes that arrive while busy=1 are dropped, not queued.
//  A cmt_EN in the same cycle as a dg_EN commits the old entry; the digit is lost.
//  Minimum commit-to-accept time: cnt_Q+1 cycles, assuming out_ready=1.
// CONFIGURATION
//  NUM_ENTRY_SIGN_EN defined: adds input port neg_EN (1 bit) and output neg_Q
//   (1 bit, reset 0).
//   - neg_EN in S_ENTRY toggles neg_Q; its priority is equal to del_EN, and
//     del_EN wins if both are asserted.
//   - clr and push clear neg_Q.
//   - On entering S_PUSH with neg_Q=1, out_data=-acc (two's complement, WIDTH bits).
//  Not defined: no neg_EN or neg_Q ports; out_data is always unsigned.
// TESTING
//  dg 1,2,3; cmt; out_ready=1 -> out_valid rises 4 cycles after cmt;
//   out_data=32'd123; cnt_Q=0 afterwards.
//  dg 0,0,5 -> cnt_Q=1, bcd_Q=5; cmt -> out_data=5.
//  dg 1..9 (9 digits) -> cnt_Q=8, ovf=1, bcd_Q=0x12345678; cmt -> out_data=12345678.
//  dg 4,7; del; dg 2 -> bcd_Q=0x42; del,del,del -> cnt_Q=0, no underflow.
//  cmt with empty entry, out_ready=0 for 5 cycles -> out_valid held with
//   out_data=0; dg strobes ignored; accepted when out_ready=1.
//  dg 9,9; cmt; Reset pulsed during S_CONV -> out_valid never asserts, all
//   outputs 0. With SIGN_EN: dg 1,5; neg; cmt -> out_data=32'hFFFFFFF1.

Source files
------------

// File: rtl/controller_num_entry.sv
// controller_num_entry: BCD digit entry with backspace/clear, multi-cycle BCD-to-binary
// conversion and valid/ready push. Optional sign toggle under NUM_ENTRY_SIGN_EN.
module controller_num_entry #(
   parameter int DIGITS = 8,
   parameter int WIDTH  = 32,
   parameter int CNT_W  = 4
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic [3:0]          dg_D,
   input  logic                dg_EN,
   input  logic                del_EN,
   input  logic                clr_EN,
   input  logic                cmt_EN,
`ifdef NUM_ENTRY_SIGN_EN
   input  logic                neg_EN,
   output logic                neg_Q,
`endif
   output logic [WIDTH-1:0]    out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [4*DIGITS-1:0] bcd_Q,
   output logic [CNT_W-1:0]    cnt_Q,
   output logic                ovf,
   output logic                busy
);
   typedef enum logic [1:0] {S_ENTRY, S_CONV, S_PUSH} state_t;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DIGITS);
   state_t state_q, state_d;
   logic [4*DIGITS-1:0] bcd_q, bcd_d, bcd_sh;
   logic [CNT_W-1:0] cnt_q, cnt_d, idx_q, idx_d;
   logic [WIDTH-1:0] acc_q, acc_d, acc_nx, out_q, out_d;
   logic ovf_q, ovf_d, neg_q, neg_d, neg_tgl;
`ifdef NUM_ENTRY_SIGN_EN
   assign neg_tgl = neg_EN;
   assign neg_Q   = neg_q;
`else
   assign neg_tgl = 1'b0;
`endif
   // idx counts down from cnt_Q; the digit in use sits at nibble idx-1
   assign bcd_sh    = bcd_q >> {idx_q - 1'b1, 2'b00};
   assign acc_nx    = (acc_q << 3) + (acc_q << 1) + WIDTH'(bcd_sh[3:0]);
   assign out_data  = out_q;
   assign out_valid = state_q == S_PUSH;
   assign busy      = state_q != S_ENTRY;
   assign bcd_Q     = bcd_q;
   assign cnt_Q     = cnt_q;
   assign ovf       = ovf_q;
   always_ff @(posedge Clock or posedge Reset)
      if (Reset) begin
         state_q <= S_ENTRY;
         bcd_q   <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         acc_q   <= '0;
         out_q   <= '0;
         ovf_q   <= 1'b0;
         neg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         out_q   <= out_d;
         ovf_q   <= ovf_d;
         neg_q   <= neg_d;
      end
   always_comb begin
      state_d = state_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      out_d   = out_q;
      ovf_d   = ovf_q;
      neg_d   = neg_q;
      case (state_q)
         S_ENTRY:
            if (clr_EN) begin
               bcd_d = '0;
               cnt_d = '0;
               ovf_d = 1'b0;
               neg_d = 1'b0;
            end else if (cmt_EN) begin
               acc_d   = '0;
               idx_d   = cnt_q;
               out_d   = cnt_q == '0 ? '0 : out_q;
               state_d = cnt_q == '0 ? S_PUSH : S_CONV;
            end else if (del_EN) begin
               if (cnt_q != '0) begin
                  bcd_d = bcd_q >> 4;
                  cnt_d = cnt_q - 1'b1;
               end
            end else if (neg_tgl) begin
               neg_d = ~neg_q;
            end else if (dg_EN && dg_D <= 4'd9 && !(dg_D == 4'd0 && cnt_q == '0)) begin
               if (cnt_q == FULL) ovf_d = 1'b1;
               else begin
                  bcd_d = {bcd_q[4*DIGITS-5:0], dg_D};
                  cnt_d = cnt_q + 1'b1;
               end
            end
         S_CONV: begin
            acc_d = acc_nx;
            idx_d = idx_q - 1'b1;
            if (idx_q == CNT_W'(1)) begin
               out_d   = neg_q ? -acc_nx : acc_nx;
               state_d = S_PUSH;
            end
         end
         S_PUSH:
            if (out_ready) begin
               bcd_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               neg_d   = 1'b0;
               state_d = S_ENTRY;
            end
         default: state_d = S_ENTRY;
      endcase
   end
endmodule

// File: tb/tb_controller_num_entry.sv
// tb_controller_num_entry: directed and random digit entry checked against a
// queue-of-digits reference model. Define NUM_ENTRY_SIGN_EN to cover the sign option.
module tb_controller_num_entry;
   logic Clock = 1'b0, Reset = 1'b1;
   logic [3:0] dg_D = '0;
   logic dg_EN = 0, del_EN = 0, clr_EN = 0, cmt_EN = 0, neg_EN = 0, out_ready = 0;
   logic [31:0] out_data, bcd_Q;
   logic [3:0] cnt_Q;
   logic out_valid, ovf, busy, neg_Q;
   int errors = 0, checks = 0;
   int unsigned mq[$];
   bit movf, mneg;
`ifdef NUM_ENTRY_SIGN_EN
   localparam bit SIGN = 1'b1;
`else
   localparam bit SIGN = 1'b0;
   assign neg_Q = 1'b0;
`endif
   controller_num_entry dut (
      .Clock(Clock), .Reset(Reset), .dg_D(dg_D), .dg_EN(dg_EN), .del_EN(del_EN),
      .clr_EN(clr_EN), .cmt_EN(cmt_EN),
`ifdef NUM_ENTRY_SIGN_EN
      .neg_EN(neg_EN), .neg_Q(neg_Q),
`endif
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .bcd_Q(bcd_Q), .cnt_Q(cnt_Q), .ovf(ovf), .busy(busy));
   always #5 Clock = ~Clock;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge Clock);
      #1;
   endtask
   function automatic logic [31:0] m_bcd();
      logic [31:0] b = '0;
      foreach (mq[i]) b = (b << 4) | 32'(mq[i]);
      return b;
   endfunction
   function automatic logic [31:0] m_val();
      logic [31:0] v = '0;
      foreach (mq[i]) v = v * 10 + 32'(mq[i]);
      return mneg ? -v : v;
   endfunction
   task automatic idle_in();
      {dg_EN, del_EN, clr_EN, cmt_EN, neg_EN} = '0;
   endtask
   task automatic rand_strobes();
      dg_D = 4'($urandom_range(0, 11));
      dg_EN = 1'($urandom);
      del_EN = 1'($urandom);
      clr_EN = 1'($urandom);
      cmt_EN = 1'($urandom);
      neg_EN = SIGN & 1'($urandom);
   endtask
   task automatic check_entry();
      chk("bcd", bcd_Q, m_bcd());
      chk("cnt", 32'(cnt_Q), 32'(mq.size()));
      chk("ovf", 32'(ovf), 32'(movf));
      chk("neg", 32'(neg_Q), 32'(mneg));
      chk("busy_idle", 32'(busy), 0);
   endtask
   // Strobes during conversion/push are random and must all be dropped
   task automatic do_commit(input int hold);
      logic [31:0] v = m_val();
      int n = 0;
      idle_in();
      chk("busy_cmt", 32'(busy), 1);
      while (!out_valid && n < 40) begin
         rand_strobes();
         out_ready = 1'($urandom);
         tick();
         n++;
      end
      chk("latency", 32'(n), 32'(mq.size()));
      chk("data", out_data, v);
      for (int i = 0; i < hold; i++) begin
         rand_strobes();
         out_ready = 1'b0;
         tick();
         chk("hold_valid", 32'(out_valid), 1);
         chk("hold_data", out_data, v);
      end
      idle_in();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      mq.delete();
      movf = 0;
      mneg = 0;
      chk("valid_drop", 32'(out_valid), 0);
      check_entry();
   endtask
   task automatic op(input bit clr, cmt, del, neg, dg, input logic [3:0] d, input int hold);
      clr_EN = clr; cmt_EN = cmt; del_EN = del; neg_EN = neg & SIGN; dg_EN = dg; dg_D = d;
      tick();
      idle_in();
      if (clr) begin
         mq.delete();
         movf = 0;
         mneg = 0;
      end else if (cmt) begin
         do_commit(hold);
         return;
      end else if (del) begin
         if (mq.size() != 0) void'(mq.pop_back());
      end else if (neg && SIGN) mneg = !mneg;
      else if (dg && d <= 9 && !(d == 0 && mq.size() == 0)) begin
         if (mq.size() == 8) movf = 1;
         else mq.push_back(int'(d));
      end
      check_entry();
   endtask
   task automatic digit(input logic [3:0] d);
      op(0, 0, 0, 0, 1, d, 0);
   endtask
   initial begin
      tick();
      tick();
      Reset = 1'b0;
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data", out_data, 0);
      check_entry();
      digit(1); digit(2); digit(3);
      op(0, 1, 0, 0, 0, 0, 0);
      digit(0); digit(0); digit(5);
      chk("lead0_bcd", bcd_Q, 32'h5);
      op(0, 1, 0, 0, 0, 0, 1);
      for (int i = 1; i <= 9; i++) digit(4'(i));
      chk("full_bcd", bcd_Q, 32'h12345678);
      chk("full_ovf", 32'(ovf), 1);
      op(0, 1, 0, 0, 0, 0, 2);
      digit(4); digit(7);
      op(0, 0, 1, 0, 0, 0, 0);
      digit(2);
      chk("del_bcd", bcd_Q, 32'h42);
      for (int i = 0; i < 3; i++) op(0, 0, 1, 0, 0, 0, 0);
      op(0, 1, 0, 0, 0, 0, 5);
      digit(8);
      op(0, 1, 0, 0, 1, 4'd3, 0);
      digit(9); digit(9);
      cmt_EN = 1'b1;
      tick();
      cmt_EN = 1'b0;
      tick();
      #2 Reset = 1'b1;
      #2 Reset = 1'b0;
      mq.delete();
      movf = 0;
      mneg = 0;
      for (int i = 0; i < 4; i++) begin
         out_ready = 1'b1;
         tick();
         chk("rst_abort_valid", 32'(out_valid), 0);
      end
      out_ready = 1'b0;
      chk("rst_abort_data", out_data, 0);
      check_entry();
      if (SIGN) begin
         digit(1); digit(5);
         op(0, 0, 0, 1, 0, 0, 0);
         op(0, 1, 0, 0, 0, 0, 0);
         chk("neg_done", 32'(neg_Q), 0);
      end
      for (int k = 0; k < 400; k++)
         op($urandom_range(0, 24) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7,
            4'($urandom_range(0, 11)), $urandom_range(0, 3));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
